// File: rtl/zhegalkin_pkg.sv
// Shared types and the single butterfly pass of the Mobius (Zhegalkin) transform.
// mobius_pass works on a MAX_SIZE-bit word, so it supports at most MAX_N variables.
package zhegalkin_pkg;

  localparam int N_VARS   = 4;
  localparam int MAX_N    = 8;
  localparam int MAX_SIZE = 1 << MAX_N;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    XFORM = 2'd1,
    OUT   = 2'd2
  } state_t;

  // Narrower words are zero-extended by the caller. Pairs never cross a block
  // of 2**N entries, so the upper zero bits cannot disturb the result.
  function automatic logic [MAX_SIZE-1:0] mobius_pass(input logic [MAX_SIZE-1:0] t,
                                                      input int pass);
    logic [MAX_SIZE-1:0] r;
    r = t;
    for (int m = 0; m < MAX_SIZE; m++) begin
      if (((m >> pass) & 1) != 0) r[m] = t[m] ^ t[m ^ (1 << pass)];
    end
    return r;
  endfunction

endpackage

// File: rtl/zhegalkin_mobius_pass.sv
// One combinational butterfly pass. It is kept separate so that an unrolled
// (all passes in parallel) variant can chain N copies of it.
module zhegalkin_mobius_pass
  import zhegalkin_pkg::*;
#(
  parameter int N      = N_VARS,
  parameter int PASS_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [(2**N)-1:0] t,
  input  logic [PASS_W-1:0] pass,
  output logic [(2**N)-1:0] t_next
);

  localparam int SIZE = 2 ** N;

  assign t_next = SIZE'(mobius_pass(MAX_SIZE'(t), int'(pass)));

endmodule

// File: rtl/zhegalkin_anf_builder.sv
// Bit-serial truth table in, ANF coefficient word out. The transform runs in
// place on the t register, one butterfly pass per clock.
module zhegalkin_anf_builder
  import zhegalkin_pkg::*;
#(
  parameter int N = N_VARS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [(2**N)-1:0] out_coef,
  output logic              busy
);

  localparam int SIZE   = 2 ** N;
  localparam int IDX_W  = (N > 0) ? N : 1;
  localparam int PASS_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(SIZE - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(N - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [PASS_W-1:0] pass_q;
  logic [SIZE-1:0]   t_q;
  logic [SIZE-1:0]   t_next;

  logic accept;
  logic last_pass;
  logic take;

  zhegalkin_mobius_pass #(.N(N), .PASS_W(PASS_W)) u_pass (
    .t      (t_q),
    .pass   (pass_q),
    .t_next (t_next)
  );

  assign accept    = in_valid & in_ready;
  assign last_pass = (pass_q == LAST_PASS);
  assign take      = out_valid & out_ready;
  assign out_coef  = t_q;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && idx_q == LAST_IDX) state_d = XFORM;
      end
      XFORM: begin
        busy = 1'b1;
        if (last_pass) state_d = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  // NOTE: t is a handful of flops rather than a RAM, so it is reset to give a defined out_coef.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      pass_q <= '0;
      t_q    <= '0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (accept) begin
            t_q[idx_q] <= in_bit;
            // idx holds at the last entry rather than wrapping.
            if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
            else                   pass_q <= '0;
          end
        end
        XFORM: begin
          t_q <= t_next;
          if (!last_pass) pass_q <= pass_q + 1'b1;
        end
        OUT: begin
          if (take) begin
            idx_q  <= '0;
            pass_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_zhegalkin_anf_builder.sv
// Directed bench for zhegalkin_anf_builder (N=4): known vectors, backpressure,
// input gaps, reset mid-operation and round trips through the transform.
module tb_zhegalkin_anf_builder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_bit;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_coef;
  logic        busy;

  int errors = 0;
  int checks = 0;

  zhegalkin_anf_builder #(.N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coef  (out_coef),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Subset-sum form of the ANF: coef[m] = XOR of f[s] over all s contained in m.
  function automatic logic [15:0] anf_ref(input logic [15:0] f);
    logic [15:0] c;
    c = '0;
    for (int m = 0; m < 16; m++)
      for (int s = 0; s < 16; s++)
        if ((s & ~m) == 0) c[m] = c[m] ^ f[s];
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [15:0] word, input int nbits, input bit gaps);
    for (int i = 0; i < nbits; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_bit   = word[i];
      tick();
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int cycles;
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    check(tag, cycles, 4);
  endtask

  task automatic take_result(input string tag, input logic [15:0] exp);
    check(tag, out_coef, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drop"}, {out_valid, in_ready}, 2'b01);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {in_ready, out_valid, busy, out_coef}, {1'b1, 1'b0, 1'b0, 16'h0000});
  endtask

  task automatic run_frame(input string tag, input logic [15:0] f, input logic [15:0] exp);
    feed(f, 16, 1'b0);
    wait_out({tag, "_lat"});
    take_result(tag, exp);
  endtask

  initial begin
    logic [15:0] held;
    logic [15:0] f;
    logic [15:0] c;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    run_frame("known", 16'h0AC5, 16'h5173);
    run_frame("ones",  16'hFFFF, 16'h0001);
    run_frame("zeros", 16'h0000, 16'h0000);
    run_frame("top",   16'h8000, 16'h8000);
    run_frame("bottom",16'h0001, 16'hFFFF);

    // Backpressure: result held, input refused, stray in_valid pulses ignored.
    feed(16'h0AC5, 16, 1'b0);
    wait_out("bp_lat");
    check("bp_coef", out_coef, 16'h5173);
    held = out_coef;
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      in_bit   = 1'b1;
      tick();
      check("bp_hold", {out_valid, in_ready, out_coef}, {1'b1, 1'b0, held});
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
    take_result("bp_release", 16'h5173);
    run_frame("bp_next", 16'hFFFF, 16'h0001);

    // Input gaps on every other cycle.
    feed(16'h0AC5, 16, 1'b1);
    wait_out("gap_lat");
    take_result("gap", 16'h5173);

    // Reset after a partial load of 7 bits.
    feed(16'h0AC5, 7, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("rst_load");

    // Reset on the edge that would apply pass 2.
    feed(16'hFFFF, 16, 1'b0);
    tick();
    tick();
    check("rst_xform_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("rst_xform");
    run_frame("after_rst", 16'h0AC5, 16'h5173);

    // Round trips: forward against the reference, then back to the original table.
    for (int r = 0; r < 16; r++) begin
      f = 16'($urandom);
      c = anf_ref(f);
      run_frame("inv_fwd", f, c);
      run_frame("inv_back", c, f);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
